// File: rtl/multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control : main control FSM for the multi-cycle MIPS datapath   |
// | Optional MC_JUMP_EN builds the JUMP state for the J opcode.               |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module multicycle_control #(
  localparam int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               mem_read,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_en,
  output logic [1:0]         pc_src,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  localparam logic [5:0] c_op_r    = 6'b000000;
  localparam logic [5:0] c_op_lw   = 6'b100011;
  localparam logic [5:0] c_op_sw   = 6'b101011;
  localparam logic [5:0] c_op_beq  = 6'b000100;
  localparam logic [5:0] c_op_addi = 6'b001000;
`ifdef MC_JUMP_EN
  localparam logic [5:0] c_op_j    = 6'b000010;
`endif

  localparam logic [1:0] c_alu_add  = 2'b00;
  localparam logic [1:0] c_alu_sub  = 2'b01;
  localparam logic [1:0] c_alu_rtyp = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEM_ADR = 4'd2,
    ST_MEM_RD  = 4'd3,
    ST_MEM_WB  = 4'd4,
    ST_MEM_WR  = 4'd5,
    ST_EXEC    = 4'd6,
    ST_ALU_WB  = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_ADDI_EX = 4'd9,
`ifdef MC_JUMP_EN
    ST_ADDI_WB = 4'd10,
    ST_JUMP    = 4'd11
`else
    ST_ADDI_WB = 4'd10
`endif
  } state_t;

  // Moore part of the control word; fetch/jump feed the mem_ready-gated PC/IR loads.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       fetch;
    logic       jump;
    logic       branch;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctl_t;

  function automatic ctl_t ctl_decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.fetch     = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = c_alu_add;
      end
      ST_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = c_alu_add;
      end
      ST_MEM_ADR, ST_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = c_alu_add;
      end
      ST_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      ST_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b00;
        c.alu_op    = c_alu_rtyp;
      end
      ST_ALU_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b00;
        c.alu_op    = c_alu_sub;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
      end
      ST_ADDI_WB: begin
        c.reg_write = 1'b1;
      end
`ifdef MC_JUMP_EN
      ST_JUMP: begin
        c.jump   = 1'b1;
        c.pc_src = 2'b10;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t r_state;
  ctl_t   r_ctl;
  state_t w_next;
  logic   w_illegal;

  always_comb begin
    w_next    = r_state;
    w_illegal = 1'b0;
    case (r_state)
      ST_FETCH:   if (mem_ready) w_next = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          c_op_lw, c_op_sw: w_next = ST_MEM_ADR;
          c_op_r:           w_next = ST_EXEC;
          c_op_beq:         w_next = ST_BRANCH;
          c_op_addi:        w_next = ST_ADDI_EX;
`ifdef MC_JUMP_EN
          c_op_j:           w_next = ST_JUMP;
`endif
          default: begin
            w_next    = ST_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      ST_MEM_ADR: w_next = (opcode == c_op_lw) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:  if (mem_ready) w_next = ST_MEM_WB;
      ST_MEM_WR:  if (mem_ready) w_next = ST_FETCH;
      ST_EXEC:    w_next = ST_ALU_WB;
      ST_ADDI_EX: w_next = ST_ADDI_WB;
      default:    w_next = ST_FETCH;
    endcase
  end

  // Control word is registered from the next state so it is valid on state entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_ctl   <= ctl_decode(ST_FETCH);
    end else begin
      r_state <= w_next;
      r_ctl   <= ctl_decode(w_next);
    end
  end

  // Reset forces every output low in the same cycle, aborting any pending access.
  assign mem_read   = rst_n & r_ctl.mem_read;
  assign mem_write  = rst_n & r_ctl.mem_write;
  assign i_or_d     = rst_n & r_ctl.i_or_d;
  assign ir_write   = rst_n & r_ctl.fetch & mem_ready;
  assign pc_write   = rst_n & ((r_ctl.fetch & mem_ready) | r_ctl.jump);
  assign pc_en      = pc_write | (rst_n & r_ctl.branch & zero);
  assign pc_src     = {2{rst_n}} & r_ctl.pc_src;
  assign reg_write  = rst_n & r_ctl.reg_write;
  assign reg_dst    = rst_n & r_ctl.reg_dst;
  assign mem_to_reg = rst_n & r_ctl.mem_to_reg;
  assign alu_src_a  = rst_n & r_ctl.alu_src_a;
  assign alu_src_b  = {2{rst_n}} & r_ctl.alu_src_b;
  assign alu_op     = {2{rst_n}} & r_ctl.alu_op;
  assign illegal_op = rst_n & w_illegal;
  assign state      = rst_n ? r_state : '0;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// tb_multicycle_control : directed cycle-by-cycle check of the multi-cycle control FSM.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        zero;
  logic        mem_read, mem_write, i_or_d, ir_write, pc_write, pc_en;
  logic [1:0]  pc_src;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, alu_op;
  logic        illegal_op;
  logic [3:0]  state;

  int checks   = 0;
  int failures = 0;

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .illegal_op (illegal_op),
    .state      (state)
  );

  always #5 clk = ~clk;

  // {mem_read,mem_write,i_or_d}_{ir_write,pc_write,pc_en}_{pc_src}_{reg_write,reg_dst,mem_to_reg}_{alu_src_a}_{alu_src_b}_{alu_op}_{illegal_op}
  logic [16:0] obs;
  assign obs = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_en, pc_src,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_op};

  localparam logic [16:0] O_ZERO   = 17'b000_000_00_000_0_00_00_0;
  localparam logic [16:0] O_F_RDY  = 17'b100_111_00_000_0_01_00_0;
  localparam logic [16:0] O_F_WAIT = 17'b100_000_00_000_0_01_00_0;
  localparam logic [16:0] O_DEC    = 17'b000_000_00_000_0_11_00_0;
  localparam logic [16:0] O_DEC_IL = 17'b000_000_00_000_0_11_00_1;
  localparam logic [16:0] O_MADR   = 17'b000_000_00_000_1_10_00_0;
  localparam logic [16:0] O_MRD    = 17'b101_000_00_000_0_00_00_0;
  localparam logic [16:0] O_MWB    = 17'b000_000_00_101_0_00_00_0;
  localparam logic [16:0] O_MWR    = 17'b011_000_00_000_0_00_00_0;
  localparam logic [16:0] O_EXEC   = 17'b000_000_00_000_1_00_10_0;
  localparam logic [16:0] O_ALUWB  = 17'b000_000_00_110_0_00_00_0;
  localparam logic [16:0] O_BR_Z1  = 17'b000_001_01_000_1_00_01_0;
  localparam logic [16:0] O_BR_Z0  = 17'b000_000_01_000_1_00_01_0;
  localparam logic [16:0] O_ADDIEX = 17'b000_000_00_000_1_10_00_0;
  localparam logic [16:0] O_ADDIWB = 17'b000_000_00_100_0_00_00_0;
  localparam logic [16:0] O_JUMP   = 17'b000_011_10_000_0_00_00_0;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // One clock cycle: apply inputs, check this cycle's state/outputs, advance.
  task automatic step(input logic rn, input logic [5:0] op, input logic rdy, input logic z,
                      input logic [3:0] exp_st, input logic [16:0] exp_o, input string tag);
    rst_n     = rn;
    opcode    = op;
    mem_ready = rdy;
    zero      = z;
    #1;
    checks++;
    assert (state === exp_st) else begin
      failures++;
      $error("FAIL %s.state observed=%0d expected=%0d", tag, state, exp_st);
    end
    checks++;
    assert (obs === exp_o) else begin
      failures++;
      $error("FAIL %s.outputs observed=%b expected=%b", tag, obs, exp_o);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; opcode = OP_R; mem_ready = 1'b0; zero = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    step(1'b0, OP_R, 1'b1, 1'b1, 4'd0, O_ZERO, "reset_hold");

    // R-type: 0,1,6,7,0
    step(1'b1, OP_R, 1'b1, 1'b0, 4'd0, O_F_RDY, "r_fetch");
    step(1'b1, OP_R, 1'b0, 1'b0, 4'd1, O_DEC,   "r_decode");
    step(1'b1, OP_R, 1'b1, 1'b0, 4'd6, O_EXEC,  "r_exec");
    step(1'b1, OP_R, 1'b0, 1'b0, 4'd7, O_ALUWB, "r_alu_wb");

    // LW with two wait cycles in MEM_RD
    step(1'b1, OP_LW, 1'b1, 1'b0, 4'd0, O_F_RDY, "lw_fetch");
    step(1'b1, OP_LW, 1'b0, 1'b0, 4'd1, O_DEC,   "lw_decode");
    step(1'b1, OP_LW, 1'b0, 1'b0, 4'd2, O_MADR,  "lw_mem_adr");
    step(1'b1, OP_LW, 1'b0, 1'b0, 4'd3, O_MRD,   "lw_rd_wait1");
    step(1'b1, OP_LW, 1'b0, 1'b0, 4'd3, O_MRD,   "lw_rd_wait2");
    step(1'b1, OP_LW, 1'b1, 1'b0, 4'd3, O_MRD,   "lw_rd_done");
    step(1'b1, OP_LW, 1'b0, 1'b0, 4'd4, O_MWB,   "lw_mem_wb");

    // SW with one FETCH wait cycle
    step(1'b1, OP_SW, 1'b0, 1'b0, 4'd0, O_F_WAIT, "sw_fetch_wait");
    step(1'b1, OP_SW, 1'b1, 1'b0, 4'd0, O_F_RDY,  "sw_fetch");
    step(1'b1, OP_SW, 1'b0, 1'b0, 4'd1, O_DEC,    "sw_decode");
    step(1'b1, OP_SW, 1'b0, 1'b0, 4'd2, O_MADR,   "sw_mem_adr");
    step(1'b1, OP_SW, 1'b1, 1'b0, 4'd5, O_MWR,    "sw_mem_wr");

    // BEQ taken and not taken
    step(1'b1, OP_BEQ, 1'b1, 1'b0, 4'd0, O_F_RDY, "beq1_fetch");
    step(1'b1, OP_BEQ, 1'b0, 1'b0, 4'd1, O_DEC,   "beq1_decode");
    step(1'b1, OP_BEQ, 1'b0, 1'b1, 4'd8, O_BR_Z1, "beq1_branch_z1");
    step(1'b1, OP_BEQ, 1'b1, 1'b1, 4'd0, O_F_RDY, "beq0_fetch");
    step(1'b1, OP_BEQ, 1'b0, 1'b0, 4'd1, O_DEC,   "beq0_decode");
    step(1'b1, OP_BEQ, 1'b0, 1'b0, 4'd8, O_BR_Z0, "beq0_branch_z0");

    // ADDI
    step(1'b1, OP_ADDI, 1'b1, 1'b0, 4'd0,  O_F_RDY,  "addi_fetch");
    step(1'b1, OP_ADDI, 1'b0, 1'b0, 4'd1,  O_DEC,    "addi_decode");
    step(1'b1, OP_ADDI, 1'b0, 1'b0, 4'd9,  O_ADDIEX, "addi_ex");
    step(1'b1, OP_ADDI, 1'b0, 1'b0, 4'd10, O_ADDIWB, "addi_wb");

    // Unsupported opcode
    step(1'b1, OP_BAD, 1'b1, 1'b0, 4'd0, O_F_RDY,  "bad_fetch");
    step(1'b1, OP_BAD, 1'b0, 1'b0, 4'd1, O_DEC_IL, "bad_decode");
    step(1'b1, OP_BAD, 1'b0, 1'b0, 4'd0, O_F_WAIT, "bad_back_fetch");

    // J
    step(1'b1, OP_J, 1'b1, 1'b0, 4'd0, O_F_RDY, "j_fetch");
`ifdef MC_JUMP_EN
    step(1'b1, OP_J, 1'b0, 1'b0, 4'd1,  O_DEC,  "j_decode");
    step(1'b1, OP_J, 1'b0, 1'b0, 4'd11, O_JUMP, "j_jump");
`else
    step(1'b1, OP_J, 1'b0, 1'b0, 4'd1,  O_DEC_IL, "j_decode_illegal");
`endif

    // Reset held 3 cycles in the middle of a MEM_RD wait
    step(1'b1, OP_LW, 1'b1, 1'b0, 4'd0, O_F_RDY, "rst_lw_fetch");
    step(1'b1, OP_LW, 1'b0, 1'b0, 4'd1, O_DEC,   "rst_lw_decode");
    step(1'b1, OP_LW, 1'b0, 1'b0, 4'd2, O_MADR,  "rst_lw_mem_adr");
    step(1'b1, OP_LW, 1'b0, 1'b0, 4'd3, O_MRD,   "rst_lw_rd_wait");
    step(1'b0, OP_LW, 1'b1, 1'b1, 4'd0, O_ZERO,  "rst_mid_rd1");
    step(1'b0, OP_LW, 1'b1, 1'b1, 4'd0, O_ZERO,  "rst_mid_rd2");
    step(1'b0, OP_LW, 1'b1, 1'b1, 4'd0, O_ZERO,  "rst_mid_rd3");
    step(1'b1, OP_LW, 1'b0, 1'b0, 4'd0, O_F_WAIT, "post_rst_fetch_wait");
    step(1'b1, OP_LW, 1'b1, 1'b0, 4'd0, O_F_RDY,  "post_rst_fetch");
    step(1'b1, OP_LW, 1'b0, 1'b0, 4'd1, O_DEC,    "post_rst_decode");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
